dispatch_scheduler: RTL and testbench
=====================================

DISPATCH_SCHEDULER -- requirements
Module: dispatch_scheduler

Interface
REQ-001 SHALL have parameters: CSU_SIZE, default 8, number of CSU entries; CSU_SIZE_BITS, default 3, entry-id width.
REQ-002 SHALL have ports, one per line:
- clk_in  in  1  system clock; all state updates on its rising edge
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  pause when low
- flush_pipline  in  1  pipeline flush
- csu_head  in  CSU_SIZE_BITS  id of oldest CSU entry
- entry_pending  in  CSU_SIZE  bit i: entry i recorded, not yet dispatched
- entry_ready  in  CSU_SIZE  bit i: entry i pending with all dependencies satisfied
- entry_is_mem  in  CSU_SIZE  bit i: entry i is a memory operation
- alu_grant  out  1  ALU slot loads this cycle
- alu_grant_id  out  CSU_SIZE_BITS  entry loaded into ALU slot
- mo_grant  out  1  memory slot loads this cycle
- mo_grant_id  out  CSU_SIZE_BITS  entry loaded into memory slot
- alu_valid  out  1  ALU slot offers an instruction
- alu_id  out  CSU_SIZE_BITS  entry in ALU slot
- alu_accept  in  1  ALU takes offered instruction
- mo_valid  out  1  memory slot offers an instruction
- mo_id  out  CSU_SIZE_BITS  entry in memory slot
- mo_accept  in  1  memory operator takes offered instruction
- mo_rdy  in  1  memory operator completes
- mo_res_ins_id  in  CSU_SIZE_BITS  id of completed memory instruction
- stall_count  out  16  cycles with a ready entry but no grant

Function
REQ-003 SHALL compute age(i) = (i - csu_head) mod CSU_SIZE; lower age is older.
REQ-004 SHALL define the ALU candidate as the oldest i with entry_ready[i] & ~entry_is_mem[i].
REQ-005 SHALL define the memory candidate as the oldest i with entry_pending[i] & entry_is_mem[i].
- It SHALL be eligible only if entry_ready[i] is also set.
- Memory operations therefore dispatch strictly in program order.
REQ-006 SHALL treat the ALU slot as free when alu_valid=0 or (alu_valid & alu_accept).
REQ-007 SHALL assert alu_grant combinationally when the ALU slot is free and an ALU candidate exists.
- alu_grant_id = candidate id.
- On that clock edge: alu_valid<=1, alu_id<=candidate.
REQ-008 SHALL clear alu_valid on alu_valid & alu_accept when no new grant occurs in the same cycle.
REQ-009 SHALL hold alu_valid and alu_id stable until accepted.
REQ-010 SHALL run the memory FSM with states IDLE, OFFER, WAIT_DONE.
REQ-011 Memory FSM transitions:
- IDLE: on eligible memory candidate, assert mo_grant/mo_grant_id, load mo_id, go to OFFER.
- OFFER: on mo_accept, go to WAIT_DONE.
- WAIT_DONE: on mo_rdy & mo_res_ins_id==mo_id, go to IDLE.
- mo_valid = (state==OFFER).
REQ-012 SHALL issue no memory grant in the cycle the FSM leaves WAIT_DONE; at most one memory op in flight.
REQ-013 SHALL allow alu_grant and mo_grant in the same cycle.
REQ-014 The CSU SHALL deassert entry_pending/entry_ready of a granted entry from the next cycle; the scheduler never grants the same id twice in consecutive cycles.
REQ-015 SHALL increment stall_count when (entry_ready != 0) & ~alu_grant & ~mo_grant & rdy_in; saturating at 16'hFFFF.
REQ-016 With rdy_in=0: grants 0, all registers hold, handshake inputs ignored.
REQ-017 With flush_pipline=1 and rdy_in=1:
- grants 0 that cycle.
- Next cycle: alu_valid=0, mo_valid=0, FSM=IDLE.
- stall_count unchanged.
REQ-018 SHALL apply flush over any simultaneous accept, completion or candidate.

Reset
REQ-019 rst_in=1 at a clock edge, regardless of rdy_in, SHALL set alu_valid=0, alu_id=0, mo_id=0, FSM=IDLE, stall_count=0; grants 0 while rst_in=1.
REQ-020 Reset mid-handshake SHALL discard the offered and in-flight instruction without waiting for mo_rdy.

Verification
REQ-021 csu_head=6, entry_ready=8'b0100_0001, entry_is_mem=0 -> alu_grant=1, alu_grant_id=6 (entry 0 younger across wrap).
REQ-022 entry_pending=8'b0000_0110, entry_is_mem=8'b0000_0110, entry_ready=8'b0000_0100, csu_head=0 -> mo_grant=0 (entry 1 older, not ready); stall_count +1 per cycle.
REQ-023 ALU offer id 3, alu_accept=0 for 4 cycles -> alu_valid=1, alu_id=3 stable; cycle with alu_accept=1 and new candidate 5 -> alu_grant_id=5, alu_valid stays 1.
REQ-024 Memory op id 2 accepted; mo_rdy with mo_res_ins_id=4 -> FSM stays WAIT_DONE; mo_rdy with id 2 -> IDLE; next eligible memory grant one cycle later.
REQ-025 Simultaneous ALU candidate 1 and memory candidate 2 -> alu_grant=1, id 1 and mo_grant=1, id 2 in the same cycle.
REQ-026 flush_pipline=1 while mo in WAIT_DONE and alu_valid=1 -> next cycle alu_valid=0, mo_valid=0, FSM=IDLE; rdy_in=0 for 3 cycles -> no state change.

Source files
------------

// File: rtl/dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// dispatch_scheduler
//
// Picks instructions out of the CSU and loads them into two one-deep issue
// slots. One slot feeds the ALU and the other feeds the memory operator.
//
// ALU slot:    each cycle it takes the oldest ready non-memory entry, whenever
//              the slot is free.
// Memory slot: it only ever looks at the oldest pending memory entry, so memory
//              operations leave in program order. A small FSM allows at most
//              one memory operation in flight at a time.
//
// Age is measured from csu_head with wrap-around:
//   age(i) = (i - csu_head) mod CSU_SIZE
// A smaller age means an older entry.
//
// Handshake rule (this applies to both slots):
//   - valid is a registered offer.
//   - Once valid is high, the slot holds valid and id stable until the consumer
//     raises its accept in a cycle where rdy_in=1.
//   - valid & accept at a rising edge counts as the transfer.
//   - accept is ignored when valid is low.
//
// Ports
//   clk_in, rst_in             clock; synchronous active-high reset
//   rdy_in                     0 pauses everything: no grants, all state held
//   flush_pipline              drops both slots, returns the FSM to idle
//   csu_head                   id of the oldest CSU entry
//   entry_pending/ready/is_mem per-entry status vectors from the CSU
//   alu_grant, alu_grant_id    combinational: ALU slot loads this entry now
//   mo_grant,  mo_grant_id     combinational: memory slot loads this entry now
//   alu_valid, alu_id          ALU slot offer;    alu_accept takes it
//   mo_valid,  mo_id           memory slot offer; mo_accept takes it
//   mo_rdy, mo_res_ins_id      the memory operator completed this instruction
//   stall_count                saturating count of cycles that had a ready
//                              entry but no grant
//   mo_state_dbg               current memory FSM state (encoding of mo_state_t)
// -----------------------------------------------------------------------------
module dispatch_scheduler #(
    parameter int CSU_SIZE      = 8,
    parameter int CSU_SIZE_BITS = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_pipline,
    input  logic [CSU_SIZE_BITS-1:0] csu_head,
    input  logic [CSU_SIZE-1:0]      entry_pending,
    input  logic [CSU_SIZE-1:0]      entry_ready,
    input  logic [CSU_SIZE-1:0]      entry_is_mem,
    output logic                     alu_grant,
    output logic [CSU_SIZE_BITS-1:0] alu_grant_id,
    output logic                     mo_grant,
    output logic [CSU_SIZE_BITS-1:0] mo_grant_id,
    output logic                     alu_valid,
    output logic [CSU_SIZE_BITS-1:0] alu_id,
    input  logic                     alu_accept,
    output logic                     mo_valid,
    output logic [CSU_SIZE_BITS-1:0] mo_id,
    input  logic                     mo_accept,
    input  logic                     mo_rdy,
    input  logic [CSU_SIZE_BITS-1:0] mo_res_ins_id,
    output logic [15:0]              stall_count,
    output logic [1:0]               mo_state_dbg
);

    typedef enum logic [1:0] {
        MO_IDLE      = 2'd0,
        MO_OFFER     = 2'd1,
        MO_WAIT_DONE = 2'd2
    } mo_state_t;

    // CSU_SIZE widened by one bit. head + offset never reaches 2*CSU_SIZE,
    // so subtracting this once is enough to wrap the index.
    localparam logic [CSU_SIZE_BITS:0] SIZE_EXT = (CSU_SIZE_BITS + 1)'(CSU_SIZE);

    mo_state_t mo_state;
    mo_state_t mo_state_next;

    logic                     alu_cand_found;
    logic [CSU_SIZE_BITS-1:0] alu_cand_id;
    logic                     mem_cand_found;
    logic [CSU_SIZE_BITS-1:0] mem_cand_id;
    logic                     mem_cand_ready;
    logic                     active;
    logic                     alu_slot_free;

    // ------------------------------------------------------------------
    // Candidate search.
    // The loop walks entries in age order, starting at csu_head, and the
    // first hit wins. The memory search stops at the oldest pending memory
    // op even when that op is not ready yet. That stop is what keeps
    // memory operations in order.
    // ------------------------------------------------------------------
    always_comb begin : cand_scan
        logic [CSU_SIZE_BITS:0]   pos;
        logic [CSU_SIZE_BITS-1:0] idx;
        alu_cand_found = 1'b0;
        alu_cand_id    = '0;
        mem_cand_found = 1'b0;
        mem_cand_id    = '0;
        pos            = '0;
        idx            = '0;
        for (int k = 0; k < CSU_SIZE; k++) begin
            pos = {1'b0, csu_head} + (CSU_SIZE_BITS + 1)'(k);
            if (pos >= SIZE_EXT) begin
                pos = pos - SIZE_EXT;
            end
            idx = pos[CSU_SIZE_BITS-1:0];
            if (!alu_cand_found && entry_ready[idx] && !entry_is_mem[idx]) begin
                alu_cand_found = 1'b1;
                alu_cand_id    = idx;
            end
            if (!mem_cand_found && entry_pending[idx] && entry_is_mem[idx]) begin
                mem_cand_found = 1'b1;
                mem_cand_id    = idx;
            end
        end
    end

    assign mem_cand_ready = entry_ready[mem_cand_id];

    // Grants are only allowed in an ordinary running cycle.
    // A reset, a pause or a flush all suppress them.
    assign active        = rdy_in && !rst_in && !flush_pipline;
    assign alu_slot_free = !alu_valid || alu_accept;

    assign alu_grant    = active && alu_slot_free && alu_cand_found;
    assign alu_grant_id = alu_cand_id;

    // Grants happen only from IDLE. This also covers the cycle in which the
    // FSM leaves WAIT_DONE: the FSM is not yet IDLE then, so that cycle gets
    // no grant.
    assign mo_grant    = active && (mo_state == MO_IDLE) && mem_cand_found && mem_cand_ready;
    assign mo_grant_id = mem_cand_id;

    assign mo_valid     = (mo_state == MO_OFFER);
    assign mo_state_dbg = mo_state;

    // ------------------------------------------------------------------
    // Memory FSM next-state logic.
    // The register only advances when rdy_in=1, so the FSM ignores
    // handshake inputs while the scheduler is paused.
    // ------------------------------------------------------------------
    always_comb begin
        mo_state_next = mo_state;
        if (flush_pipline) begin
            mo_state_next = MO_IDLE;
        end else begin
            unique case (mo_state)
                MO_IDLE: begin
                    if (mo_grant) begin
                        mo_state_next = MO_OFFER;
                    end
                end
                MO_OFFER: begin
                    if (mo_accept) begin
                        mo_state_next = MO_WAIT_DONE;
                    end
                end
                MO_WAIT_DONE: begin
                    if (mo_rdy && (mo_res_ins_id == mo_id)) begin
                        mo_state_next = MO_IDLE;
                    end
                end
                default: begin
                    mo_state_next = MO_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // Reset drops any offered or in-flight instruction immediately.
            // It does not wait for mo_rdy.
            mo_state <= MO_IDLE;
        end else if (rdy_in) begin
            mo_state <= mo_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Issue slots and stall counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_valid   <= 1'b0;
            alu_id      <= '0;
            mo_id       <= '0;
            stall_count <= '0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                // A flush overrides any accept, completion or candidate in
                // the same cycle. stall_count is deliberately left alone.
                alu_valid <= 1'b0;
            end else begin
                // A new grant in the same cycle as an accept simply reloads
                // the slot, so alu_valid stays high without a gap.
                if (alu_grant) begin
                    alu_valid <= 1'b1;
                    alu_id    <= alu_cand_id;
                end else if (alu_valid && alu_accept) begin
                    alu_valid <= 1'b0;
                end

                if (mo_grant) begin
                    mo_id <= mem_cand_id;
                end

                if ((entry_ready != '0) && !alu_grant && !mo_grant) begin
                    if (stall_count != 16'hFFFF) begin
                        stall_count <= stall_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dispatch_scheduler
//
// Directed bench for dispatch_scheduler.
//   - A table of single-cycle vectors covers candidate selection. Each
//     vector starts from a fresh reset.
//   - Hand-written sequences cover the multi-cycle behaviour: stalls, ALU
//     back-pressure, memory completion matching, flush, pause, and reset
//     in the middle of a handshake.
// -----------------------------------------------------------------------------
module tb_dispatch_scheduler;

    localparam int N  = 8;
    localparam int NB = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst_in;
    logic          rdy_in;
    logic          flush_pipline;
    logic [NB-1:0] csu_head;
    logic [N-1:0]  entry_pending;
    logic [N-1:0]  entry_ready;
    logic [N-1:0]  entry_is_mem;
    logic          alu_grant;
    logic [NB-1:0] alu_grant_id;
    logic          mo_grant;
    logic [NB-1:0] mo_grant_id;
    logic          alu_valid;
    logic [NB-1:0] alu_id;
    logic          alu_accept;
    logic          mo_valid;
    logic [NB-1:0] mo_id;
    logic          mo_accept;
    logic          mo_rdy;
    logic [NB-1:0] mo_res_ins_id;
    logic [15:0]   stall_count;
    logic [1:0]    mo_state_dbg;

    dispatch_scheduler #(.CSU_SIZE(N), .CSU_SIZE_BITS(NB)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .csu_head      (csu_head),
        .entry_pending (entry_pending),
        .entry_ready   (entry_ready),
        .entry_is_mem  (entry_is_mem),
        .alu_grant     (alu_grant),
        .alu_grant_id  (alu_grant_id),
        .mo_grant      (mo_grant),
        .mo_grant_id   (mo_grant_id),
        .alu_valid     (alu_valid),
        .alu_id        (alu_id),
        .alu_accept    (alu_accept),
        .mo_valid      (mo_valid),
        .mo_id         (mo_id),
        .mo_accept     (mo_accept),
        .mo_rdy        (mo_rdy),
        .mo_res_ins_id (mo_res_ins_id),
        .stall_count   (stall_count),
        .mo_state_dbg  (mo_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge, then move 1 time unit past it. Inputs are
    // driven and registered outputs are sampled at that point.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_entries(input logic [NB-1:0] head, input logic [N-1:0] pend,
                               input logic [N-1:0] rdy, input logic [N-1:0] mem);
        csu_head      = head;
        entry_pending = pend;
        entry_ready   = rdy;
        entry_is_mem  = mem;
    endtask

    task automatic idle_inputs();
        rdy_in        = 1'b1;
        flush_pipline = 1'b0;
        alu_accept    = 1'b0;
        mo_accept     = 1'b0;
        mo_rdy        = 1'b0;
        mo_res_ins_id = '0;
        set_entries(3'd0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NB-1:0] head;
        logic [N-1:0]  pend;
        logic [N-1:0]  rdy;
        logic [N-1:0]  mem;
        logic          exp_ag;
        logic [NB-1:0] exp_aid;
        logic          exp_mg;
        logic [NB-1:0] exp_mid;
        logic [15:0]   exp_stall;
    } vec_t;

    vec_t vecs[9];

    initial begin
        rst_in = 1'b1;
        idle_inputs();

        //          head  pend   ready  mem    ag    aid   mg    mid   stall
        vecs[0] = '{3'd6, 8'h41, 8'h41, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0, 16'd0}; // wrap: 6 older than 0
        vecs[1] = '{3'd0, 8'h0A, 8'h0A, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 16'd0};
        vecs[2] = '{3'd3, 8'h85, 8'h85, 8'h00, 1'b1, 3'd7, 1'b0, 3'd0, 16'd0}; // age(7)=4 beats 0,2
        vecs[3] = '{3'd0, 8'h06, 8'h06, 8'h04, 1'b1, 3'd1, 1'b1, 3'd2, 16'd0}; // dual grant
        vecs[4] = '{3'd0, 8'h06, 8'h04, 8'h06, 1'b0, 3'd0, 1'b0, 3'd0, 16'd1}; // older mem op 1 not ready
        vecs[5] = '{3'd5, 8'hA0, 8'h80, 8'hA0, 1'b0, 3'd0, 1'b0, 3'd0, 16'd1}; // mem 5 blocks ready 7
        vecs[6] = '{3'd5, 8'h09, 8'h09, 8'h09, 1'b0, 3'd0, 1'b1, 3'd0, 16'd0}; // mem 0 older than 3
        vecs[7] = '{3'd2, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0}; // nothing
        vecs[8] = '{3'd7, 8'h81, 8'h81, 8'h80, 1'b1, 3'd0, 1'b1, 3'd7, 16'd0}; // mem at head, alu wraps

        // ---- reset state ----
        step();
        rst_in = 1'b0;
        check("rst_alu_valid", alu_valid, 0);
        check("rst_alu_id", alu_id, 0);
        check("rst_mo_valid", mo_valid, 0);
        check("rst_mo_id", mo_id, 0);
        check("rst_stall", stall_count, 0);
        check("rst_state", mo_state_dbg, ST_IDLE);

        // ---- table-driven vectors ----
        for (int v = 0; v < 9; v++) begin
            do_reset();
            set_entries(vecs[v].head, vecs[v].pend, vecs[v].rdy, vecs[v].mem);
            #1;
            check($sformatf("v%0d_alu_grant", v), alu_grant, vecs[v].exp_ag);
            check($sformatf("v%0d_mo_grant", v), mo_grant, vecs[v].exp_mg);
            if (vecs[v].exp_ag) check($sformatf("v%0d_alu_grant_id", v), alu_grant_id, vecs[v].exp_aid);
            if (vecs[v].exp_mg) check($sformatf("v%0d_mo_grant_id", v), mo_grant_id, vecs[v].exp_mid);
            step();
            check($sformatf("v%0d_stall", v), stall_count, vecs[v].exp_stall);
            check($sformatf("v%0d_alu_valid", v), alu_valid, vecs[v].exp_ag);
            check($sformatf("v%0d_mo_valid", v), mo_valid, vecs[v].exp_mg);
            if (vecs[v].exp_ag) check($sformatf("v%0d_alu_id", v), alu_id, vecs[v].exp_aid);
            if (vecs[v].exp_mg) check($sformatf("v%0d_mo_id", v), mo_id, vecs[v].exp_mid);
        end

        // ---- stall counting while the oldest memory op is not ready ----
        do_reset();
        set_entries(3'd0, 8'h06, 8'h04, 8'h06);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_mo_grant", mo_grant, 0);
            step();
        end
        check("stall_count3", stall_count, 3);

        // ---- ALU back-pressure, then accept together with a new grant ----
        do_reset();
        set_entries(3'd0, 8'h08, 8'h08, 8'h00);
        #1;
        check("bp_grant", alu_grant, 1);
        check("bp_grant_id", alu_grant_id, 3);
        step();
        set_entries(3'd0, 8'h20, 8'h20, 8'h00);
        for (int c = 0; c < 4; c++) begin
            check("bp_hold_valid", alu_valid, 1);
            check("bp_hold_id", alu_id, 3);
            check("bp_no_grant", alu_grant, 0);
            step();
        end
        alu_accept = 1'b1;
        #1;
        check("bp_acc_grant", alu_grant, 1);
        check("bp_acc_grant_id", alu_grant_id, 5);
        step();
        check("bp_reload_valid", alu_valid, 1);
        check("bp_reload_id", alu_id, 5);
        set_entries(3'd0, 8'h00, 8'h00, 8'h00);
        step();
        check("bp_drain_valid", alu_valid, 0);
        alu_accept = 1'b0;

        // ---- memory completion must match mo_id ----
        do_reset();
        set_entries(3'd0, 8'h04, 8'h04, 8'h04);
        #1;
        check("mem_grant", mo_grant, 1);
        check("mem_grant_id", mo_grant_id, 2);
        step();
        set_entries(3'd0, 8'h00, 8'h00, 8'h00);
        check("mem_offer_state", mo_state_dbg, ST_OFFER);
        check("mem_offer_valid", mo_valid, 1);
        check("mem_offer_id", mo_id, 2);
        mo_accept = 1'b1;
        step();
        mo_accept = 1'b0;
        check("mem_wait_state", mo_state_dbg, ST_WAIT);
        check("mem_wait_valid", mo_valid, 0);
        set_entries(3'd0, 8'h08, 8'h08, 8'h08);
        mo_rdy        = 1'b1;
        mo_res_ins_id = 3'd4;
        #1;
        check("mem_wait_no_grant", mo_grant, 0);
        step();
        check("mem_wrong_id_state", mo_state_dbg, ST_WAIT);
        mo_res_ins_id = 3'd2;
        #1;
        check("mem_leave_no_grant", mo_grant, 0);
        step();
        mo_rdy = 1'b0;
        check("mem_done_state", mo_state_dbg, ST_IDLE);
        #1;
        check("mem_next_grant", mo_grant, 1);
        check("mem_next_grant_id", mo_grant_id, 3);
        step();
        check("mem_next_offer_id", mo_id, 3);
        check("mem_next_offer_valid", mo_valid, 1);

        // ---- flush while the memory op is in flight and the ALU slot is full ----
        do_reset();
        set_entries(3'd0, 8'h06, 8'h06, 8'h04);
        step();
        set_entries(3'd0, 8'h00, 8'h00, 8'h00);
        mo_accept = 1'b1;
        step();
        mo_accept = 1'b0;
        check("fl_pre_state", mo_state_dbg, ST_WAIT);
        check("fl_pre_alu_valid", alu_valid, 1);
        check("fl_pre_alu_id", alu_id, 1);
        flush_pipline = 1'b1;
        alu_accept    = 1'b1;
        mo_rdy        = 1'b1;
        mo_res_ins_id = 3'd2;
        set_entries(3'd0, 8'h20, 8'h20, 8'h00);
        #1;
        check("fl_alu_grant", alu_grant, 0);
        check("fl_mo_grant", mo_grant, 0);
        step();
        idle_inputs();
        check("fl_alu_valid", alu_valid, 0);
        check("fl_mo_valid", mo_valid, 0);
        check("fl_state", mo_state_dbg, ST_IDLE);
        check("fl_stall", stall_count, 0);

        // ---- pause: rdy_in=0 holds everything for 3 cycles ----
        set_entries(3'd0, 8'h50, 8'h50, 8'h40);
        #1;
        check("ps_alu_grant_id", alu_grant_id, 4);
        check("ps_mo_grant_id", mo_grant_id, 6);
        step();
        rdy_in        = 1'b0;
        alu_accept    = 1'b1;
        mo_accept     = 1'b1;
        mo_rdy        = 1'b1;
        mo_res_ins_id = 3'd6;
        set_entries(3'd0, 8'h01, 8'h01, 8'h00);
        #1;
        check("ps_alu_grant", alu_grant, 0);
        check("ps_mo_grant", mo_grant, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("ps_alu_valid", alu_valid, 1);
            check("ps_alu_id", alu_id, 4);
            check("ps_state", mo_state_dbg, ST_OFFER);
            check("ps_mo_id", mo_id, 6);
            check("ps_stall", stall_count, 0);
        end

        // ---- reset mid-handshake while paused ----
        rst_in = 1'b1;
        #1;
        check("rh_alu_grant", alu_grant, 0);
        check("rh_mo_grant", mo_grant, 0);
        step();
        rst_in = 1'b0;
        check("rh_alu_valid", alu_valid, 0);
        check("rh_alu_id", alu_id, 0);
        check("rh_mo_valid", mo_valid, 0);
        check("rh_mo_id", mo_id, 0);
        check("rh_state", mo_state_dbg, ST_IDLE);
        check("rh_stall", stall_count, 0);

        // ---- final report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
